div_sequencer: RTL and testbench



---
 rtl/div_sequencer.sv | 114 +++++++++++
 tb/tb_div_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multicycle restoring unsigned divider for the divide instruction.
// Produces one quotient bit per clock and stalls the front of the pipeline while in flight.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic             Stall
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} divState;

  divState          state;
  divState          nextState;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divReg;
  logic [CW-1:0]    stepCount;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic             lastStep;

  assign lastStep = (stepCount == LastStep);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // A zero divisor skips RUN entirely so the exception result retires a cycle later.
  always_comb begin
    nextState = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    Stall     = 1'b0;
    case (state)
      IDLE: begin
        Stall = Start;
        if (Start) nextState = (Divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        Busy  = 1'b1;
        Stall = 1'b1;
        if (lastStep) nextState = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
  always_comb begin
    trial   = {remReg, quoReg[WIDTH-1]};
    remNext = trial[WIDTH-1:0];
    quoNext = {quoReg[WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, divReg}) begin
      remNext    = WIDTH'(trial - {1'b0, divReg});
      quoNext[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remReg    <= '0;
      quoReg    <= '0;
      divReg    <= '0;
      stepCount <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            divReg    <= Divisor;
            remReg    <= '0;
            quoReg    <= Dividend;
            stepCount <= '0;
            DivByZero <= (Divisor == '0);
            Quotient  <= (Divisor == '0) ? '1 : '0;
            Remainder <= (Divisor == '0) ? Dividend : '0;
          end
        end
        RUN: begin
          remReg    <= remNext;
          quoReg    <= quoNext;
          stepCount <= stepCount + CW'(1);
          if (lastStep) begin
            Quotient  <= quoNext;
            Remainder <= remNext;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scenario tasks for div_sequencer, checked against a plain
// arithmetic reference (a/b, a%b, with the divide-by-zero convention).
module tb_div_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic             Stall;

  int total = 0;
  int bad   = 0;

  int               obsLatency;
  int               obsBusy;
  int               obsStall;
  int               obsDone;
  logic             obsStartStall;
  logic             obsStallInDone;
  logic             obsOverlap;
  logic             obsAbortZero;
  logic [WIDTH-1:0] obsQ;
  logic [WIDTH-1:0] obsR;
  logic             obsDz;

  div_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .Dividend(Dividend),
    .Divisor(Divisor),
    .Quotient(Quotient),
    .Remainder(Remainder),
    .Busy(Busy),
    .Done(Done),
    .DivByZero(DivByZero),
    .Stall(Stall)
  );

  always #5 clk = ~clk;

  function automatic void refDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                 output logic dz, output int lat);
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0; lat = WIDTH + 1;
    end
  endfunction

  // Starts a divide in the next cycle, scrambles operands afterwards, and records what the DUT did
  // until Done or a 60-cycle budget; optional re-Start and reset injections at given cycles.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input int restartAt, input logic [WIDTH-1:0] ra,
                               input logic [WIDTH-1:0] rb, input int resetAt);
    @(posedge clk); #1;
    Dividend = a; Divisor = b; Start = 1'b1;
    #1;
    obsStartStall = Stall;
    obsStall = Stall ? 1 : 0;
    obsLatency = -1; obsBusy = 0; obsDone = 0;
    obsOverlap = 1'b0; obsStallInDone = 1'b1; obsAbortZero = 1'b0;
    obsQ = 'x; obsR = 'x; obsDz = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      Start = (k == restartAt);
      if (k == restartAt) begin
        Dividend = ra; Divisor = rb;
      end else begin
        Dividend = $urandom; Divisor = $urandom;
      end
      reset = (k == resetAt);
      #1;
      if (resetAt > 0 && k == resetAt + 1)
        obsAbortZero = (Quotient == 0) && (Remainder == 0) && !Busy && !Done && !DivByZero && !Stall;
      if (Busy) obsBusy++;
      if (Stall) obsStall++;
      if (Busy && Done) obsOverlap = 1'b1;
      if (Done) begin
        obsDone++;
        obsLatency = k;
        obsQ = Quotient; obsR = Remainder; obsDz = DivByZero;
        obsStallInDone = Stall;
        break;
      end
    end
    Start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b1; Dividend = 100; Divisor = 7;
    repeat (2) @(posedge clk);
    #1;
    total++; if (Quotient !== 0)  begin bad++; $display("[TB] FAIL reset_quotient: got %0h want 0", Quotient); end
    total++; if (Remainder !== 0) begin bad++; $display("[TB] FAIL reset_remainder: got %0h want 0", Remainder); end
    total++; if (Busy !== 1'b0)   begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", Busy); end
    total++; if (Done !== 1'b0)   begin bad++; $display("[TB] FAIL reset_done: got %b want 0", Done); end
    total++; if (DivByZero !== 1'b0) begin bad++; $display("[TB] FAIL reset_dz: got %b want 0", DivByZero); end
    reset = 1'b0; Start = 1'b0;
    @(posedge clk); #1;
    total++; if (Busy !== 1'b0)  begin bad++; $display("[TB] FAIL reset_idle_busy: got %b want 0", Busy); end
    total++; if (Stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle_stall: got %b want 0", Stall); end
  endtask

  task automatic test_basic();
    applyStimulus(100, 7, 0, 0, 0, 0);
    total++; if (obsStartStall !== 1'b1) begin bad++; $display("[TB] FAIL basic_start_stall: got %b want 1", obsStartStall); end
    total++; if (obsLatency != WIDTH + 1) begin bad++; $display("[TB] FAIL basic_latency: got %0d want %0d", obsLatency, WIDTH + 1); end
    total++; if (obsBusy != WIDTH) begin bad++; $display("[TB] FAIL basic_busy_cycles: got %0d want %0d", obsBusy, WIDTH); end
    total++; if (obsStall != WIDTH + 1) begin bad++; $display("[TB] FAIL basic_stall_cycles: got %0d want %0d", obsStall, WIDTH + 1); end
    total++; if (obsQ !== 14) begin bad++; $display("[TB] FAIL basic_quotient: got %0d want 14", obsQ); end
    total++; if (obsR !== 2)  begin bad++; $display("[TB] FAIL basic_remainder: got %0d want 2", obsR); end
    total++; if (obsDz !== 1'b0) begin bad++; $display("[TB] FAIL basic_dz: got %b want 0", obsDz); end
    total++; if (obsStallInDone !== 1'b0) begin bad++; $display("[TB] FAIL basic_stall_in_done: got %b want 0", obsStallInDone); end
    total++; if (obsOverlap !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_done_overlap: got %b want 0", obsOverlap); end
    @(posedge clk); #1;
    total++; if (Done !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_pulse_width: got %b want 0", Done); end
    total++; if (Quotient !== 14 || Remainder !== 2)
      begin bad++; $display("[TB] FAIL basic_hold: got q=%0d r=%0d want q=14 r=2", Quotient, Remainder); end
  endtask

  task automatic test_extremes();
    logic [WIDTH-1:0] eq, er; logic edz; int elat;
    refDiv(32'hFFFF_FFFF, 1, eq, er, edz, elat);
    applyStimulus(32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    total++; if (obsQ !== eq || obsR !== er)
      begin bad++; $display("[TB] FAIL extreme_max_by_one: got q=%0h r=%0h want q=%0h r=%0h", obsQ, obsR, eq, er); end
    refDiv(5, 32'hFFFF_FFFF, eq, er, edz, elat);
    applyStimulus(5, 32'hFFFF_FFFF, 0, 0, 0, 0);
    total++; if (obsQ !== eq || obsR !== er)
      begin bad++; $display("[TB] FAIL extreme_small_by_max: got q=%0h r=%0h want q=%0h r=%0h", obsQ, obsR, eq, er); end
  endtask

  task automatic test_div_zero();
    applyStimulus(42, 0, 0, 0, 0, 0);
    total++; if (obsLatency != 1) begin bad++; $display("[TB] FAIL dz_latency: got %0d want 1", obsLatency); end
    total++; if (obsStall != 1)   begin bad++; $display("[TB] FAIL dz_stall_cycles: got %0d want 1", obsStall); end
    total++; if (obsBusy != 0)    begin bad++; $display("[TB] FAIL dz_busy_cycles: got %0d want 0", obsBusy); end
    total++; if (obsQ !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL dz_quotient: got %0h want ffffffff", obsQ); end
    total++; if (obsR !== 42) begin bad++; $display("[TB] FAIL dz_remainder: got %0d want 42", obsR); end
    total++; if (obsDz !== 1'b1) begin bad++; $display("[TB] FAIL dz_flag: got %b want 1", obsDz); end
  endtask

  task automatic test_restart_ignored();
    logic [WIDTH-1:0] eq, er; logic edz; int elat; int extraDone;
    refDiv(1000, 13, eq, er, edz, elat);
    applyStimulus(1000, 13, 10, 77, 5, 0);
    extraDone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (Done) extraDone++;
    end
    total++; if (obsQ !== eq || obsR !== er)
      begin bad++; $display("[TB] FAIL restart_result: got q=%0d r=%0d want q=%0d r=%0d", obsQ, obsR, eq, er); end
    total++; if (obsLatency != elat) begin bad++; $display("[TB] FAIL restart_latency: got %0d want %0d", obsLatency, elat); end
    total++; if (obsDone + extraDone != 1) begin bad++; $display("[TB] FAIL restart_done_count: got %0d want 1", obsDone + extraDone); end
  endtask

  task automatic test_reset_midrun();
    applyStimulus(200, 3, 0, 0, 0, 15);
    total++; if (obsAbortZero !== 1'b1) begin bad++; $display("[TB] FAIL abort_outputs_zero: got %b want 1", obsAbortZero); end
    total++; if (obsDone != 0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d want 0", obsDone); end
    applyStimulus(9, 3, 0, 0, 0, 0);
    total++; if (obsQ !== 3 || obsR !== 0)
      begin bad++; $display("[TB] FAIL abort_next_result: got q=%0d r=%0d want q=3 r=0", obsQ, obsR); end
    total++; if (obsLatency != WIDTH + 1) begin bad++; $display("[TB] FAIL abort_next_latency: got %0d want %0d", obsLatency, WIDTH + 1); end
  endtask

  task automatic test_back_to_back();
    logic firstStallInDone;
    applyStimulus(50, 6, 0, 0, 0, 0);
    firstStallInDone = obsStallInDone;
    total++; if (obsQ !== 8 || obsR !== 2)
      begin bad++; $display("[TB] FAIL b2b_first: got q=%0d r=%0d want q=8 r=2", obsQ, obsR); end
    applyStimulus(81, 9, 0, 0, 0, 0);
    total++; if (firstStallInDone !== 1'b0 || obsStartStall !== 1'b1)
      begin bad++; $display("[TB] FAIL b2b_stall_gap: got done_stall=%b start_stall=%b want 0 1", firstStallInDone, obsStartStall); end
    total++; if (obsQ !== 9 || obsR !== 0)
      begin bad++; $display("[TB] FAIL b2b_second: got q=%0d r=%0d want q=9 r=0", obsQ, obsR); end
    total++; if (obsLatency != WIDTH + 1) begin bad++; $display("[TB] FAIL b2b_latency: got %0d want %0d", obsLatency, WIDTH + 1); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b, eq, er; logic edz; int elat;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 0;
        1:       b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      refDiv(a, b, eq, er, edz, elat);
      applyStimulus(a, b, 0, 0, 0, 0);
      total++; if (obsQ !== eq || obsR !== er || obsDz !== edz || obsLatency != elat)
        begin bad++; $display("[TB] FAIL random_%0d: a=%0h b=%0h got q=%0h r=%0h dz=%b lat=%0d want q=%0h r=%0h dz=%b lat=%0d",
                              i, a, b, obsQ, obsR, obsDz, obsLatency, eq, er, edz, elat); end
    end
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Dividend = '0; Divisor = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_restart_ignored();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
